timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter: TICK_DIV, default 1, number of clk cycles per count decrement (legal range >=1).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: sel  input  1  device selected by the CPU data-bus address decode.
REQ-005 SHALL have port: addr  input  32  CPU data address; only addr[3:2] decoded.
REQ-006 SHALL have port: byteen  input  4  CPU store byte enables.
REQ-007 SHALL have port: wdata  input  32  CPU store data.
REQ-008 SHALL have port: rdata  output  32  register read data.
REQ-009 SHALL have port: irq  output  1  interrupt request to one CPU HWInt line.

Function
REQ-010 SHALL perform a register write only when sel=1 and byteen=4'b1111; any other byteen with sel=1 SHALL be ignored.
REQ-011 SHALL map registers: addr[3:2]=0 CTRL (RW), 1 PRESET (RW), 2 COUNT (read-only, writes ignored), 3 reserved (reads 0, writes ignored).
REQ-012 SHALL define CTRL fields: [0] EN, [2:1] MODE, [3] IM; bits [31:4] SHALL read 0 and ignore writes.
REQ-013 SHALL drive rdata combinationally from addr[3:2] regardless of sel.
REQ-014 SHALL treat MODE 0, 2, 3 as one-shot and MODE 1 as auto-reload.
REQ-015 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-016 IDLE: if EN=1 go to LOAD next edge; otherwise stay.
REQ-017 LOAD: COUNT <= PRESET; go to CNT.
REQ-018 CNT: if EN=0 go to IDLE with COUNT held; else on each tick: if COUNT==0 go to INT, else COUNT <= COUNT-1.
REQ-019 SHALL generate a tick on the last cycle of every TICK_DIV-cycle period counted in CNT; the prescale counter SHALL clear whenever the state is not CNT.
REQ-020 On entry to INT SHALL set irq_pend=1.
REQ-021 INT, one-shot: CTRL.EN <= 0; go to IDLE; irq_pend SHALL remain 1 until the next CTRL write.
REQ-022 INT, auto-reload: go to LOAD; irq_pend SHALL clear on the following edge (one-cycle pulse).
REQ-023 Any accepted CTRL write SHALL clear irq_pend.
REQ-024 SHALL drive irq = irq_pend & CTRL.IM, with no combinational path from bus inputs.
REQ-025 A bus CTRL write in the same cycle that INT clears EN SHALL take priority; the written value is stored.
REQ-026 A PRESET write during CNT SHALL NOT alter COUNT and SHALL take effect only at the next LOAD.
REQ-027 PRESET=0 SHALL reach INT on the first tick in CNT.
REQ-028 COUNT SHALL never wrap below 0.
REQ-029 With TICK_DIV=1, irq_pend SHALL rise at edge t+N+3, where t is the edge of the EN write and N = PRESET.

Reset
REQ-030 On reset at a clk edge SHALL set CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0, prescale counter=0; hence irq=0 and rdata=0 for addresses 0/4/8.
REQ-031 Reset asserted mid-count or in INT SHALL abort the operation with no irq pulse afterwards.

Verification
REQ-032 SHALL verify one-shot: TICK_DIV=1; PRESET=5; write CTRL=0x9 at edge t -> COUNT reads 5,4,...,0; irq=1 from edge t+8 and held; CTRL reads 0x8; irq clears after a CTRL write of 0x8.
REQ-033 SHALL verify auto-reload: PRESET=2, CTRL=0xB -> irq is a one-cycle pulse every 5 cycles, repeating; CTRL.EN stays 1.
REQ-034 SHALL verify masking and partial writes: CTRL=0x1 with PRESET=3 -> irq stays 0 while irq_pend sets; a write of byteen=4'b0011 to PRESET leaves PRESET unchanged; a write to COUNT is ignored.
REQ-035 SHALL verify pause: CTRL=0x1 write during CNT at COUNT=7, then write CTRL=0x0 -> COUNT holds 7 in IDLE; re-enabling reloads PRESET.
REQ-036 SHALL verify the prescaler: TICK_DIV=4, PRESET=2, one-shot, IM=1 -> COUNT decrements every 4 cycles; irq rises at edge t+14.
REQ-037 SHALL verify reset mid-operation: reset pulsed during CNT at COUNT=3 -> all registers 0 and irq=0 on the next edge, with no later irq.

Source files
------------

// File: rtl/timer_if.sv
// ============================================================================
// Module      : timer_if
// Description : CPU data-bus port bundle for the timer_counter block.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface timer_if;
   logic        sel;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output sel, addr, byteen, wdata,
      input  rdata, irq
   );

   modport slave (
      input  sel, addr, byteen, wdata,
      output rdata, irq
   );
endinterface

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// Module      : timer_counter
// Description : Memory-mapped down-counting timer with prescaler and IRQ.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module timer_counter #(
   parameter int TICK_DIV = 1
) (
   input  logic   clk,
   input  logic   reset,
   timer_if.slave bus
);

   localparam int            c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_LOAD = 2'd1;
   localparam logic [1:0] c_S_CNT  = 2'd2;
   localparam logic [1:0] c_S_INT  = 2'd3;

   logic [1:0]      r_state;
   logic [3:0]      r_ctrl;
   logic [31:0]     r_preset;
   logic [31:0]     r_count;
   logic [c_PW-1:0] r_presc;
   logic            r_irq_pend;

   logic            w_wr;
   logic            w_wr_ctrl;
   logic            w_wr_preset;
   logic            w_tick;
   logic            w_unused;

   assign w_wr        = bus.sel && (bus.byteen == 4'b1111);
   assign w_wr_ctrl   = w_wr && (bus.addr[3:2] == 2'd0);
   assign w_wr_preset = w_wr && (bus.addr[3:2] == 2'd1);
   assign w_tick      = (r_presc == c_TICK_LAST);
   assign w_unused    = ^{bus.addr[31:4], bus.addr[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= c_S_IDLE;
         r_ctrl     <= 4'd0;
         r_preset   <= 32'd0;
         r_count    <= 32'd0;
         r_presc    <= '0;
         r_irq_pend <= 1'b0;
      end else begin
         if ((r_state == c_S_CNT) && !w_tick)
            r_presc <= r_presc + c_PW'(1);
         else
            r_presc <= '0;

         case (r_state)
            c_S_IDLE: begin
               if (r_ctrl[0])
                  r_state <= c_S_LOAD;
            end
            c_S_LOAD: begin
               r_count <= r_preset;
               r_state <= c_S_CNT;
            end
            c_S_CNT: begin
               if (!r_ctrl[0]) begin
                  r_state <= c_S_IDLE;
               end else if (w_tick) begin
                  if (r_count == 32'd0) begin
                     r_state    <= c_S_INT;
                     r_irq_pend <= 1'b1;
                  end else begin
                     r_count <= r_count - 32'd1;
                  end
               end
            end
            c_S_INT: begin
               if (r_ctrl[2:1] == 2'd1) begin
                  r_state    <= c_S_LOAD;
                  r_irq_pend <= 1'b0;
               end else begin
                  r_ctrl[0] <= 1'b0;
                  r_state   <= c_S_IDLE;
               end
            end
            default: r_state <= c_S_IDLE;
         endcase

         // Bus writes come last so they override any same-cycle FSM update.
         if (w_wr_ctrl) begin
            r_ctrl     <= bus.wdata[3:0];
            r_irq_pend <= 1'b0;
         end
         if (w_wr_preset)
            r_preset <= bus.wdata;
      end
   end

   always_comb begin
      bus.rdata = 32'd0;
      case (bus.addr[3:2])
         2'd0:    bus.rdata = {28'd0, r_ctrl};
         2'd1:    bus.rdata = r_preset;
         2'd2:    bus.rdata = r_count;
         default: bus.rdata = 32'd0;
      endcase
   end

   assign bus.irq = r_irq_pend & r_ctrl[3];

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ============================================================================
// Module      : tb_timer_counter
// Description : Directed self-checking bench for timer_counter (TICK_DIV 1 and 4).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_timer_counter;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   timer_if b1 ();
   timer_if b4 ();

   timer_counter #(.TICK_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
   timer_counter #(.TICK_DIV(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Write lands on the next rising edge; returns 1ns after that edge.
   task automatic wr(input bit d4, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      @(negedge clk);
      if (d4) begin
         b4.sel = 1'b1; b4.addr = a; b4.byteen = be; b4.wdata = d;
      end else begin
         b1.sel = 1'b1; b1.addr = a; b1.byteen = be; b1.wdata = d;
      end
      @(posedge clk);
      #1;
      b1.sel = 1'b0; b1.byteen = 4'd0;
      b4.sel = 1'b0; b4.byteen = 4'd0;
   endtask

   task automatic rd(input bit d4, input logic [31:0] a, output logic [31:0] v);
      if (d4) b4.addr = a; else b1.addr = a;
      #1;
      v = d4 ? b4.rdata : b1.rdata;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      for (int i = 0; i < 4; i++) begin
         rd(1'b0, 32'(i * 4), v);
         checks++;
         if (v !== 32'd0) begin errors++; $display("FAIL reset_rd%0d dut1: got %h expected 0", i, v); end
         rd(1'b1, 32'(i * 4), v);
         checks++;
         if (v !== 32'd0) begin errors++; $display("FAIL reset_rd%0d dut4: got %h expected 0", i, v); end
      end
      checks++;
      if (b1.irq !== 1'b0 || b4.irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq: got %b/%b expected 0/0", b1.irq, b4.irq);
      end
   endtask

   task automatic test_one_shot;
      logic [31:0] v;
      wr(1'b0, 32'h4, 4'hF, 32'd5);
      wr(1'b0, 32'h0, 4'hF, 32'h9);      // edge t
      step(2);                           // t+2
      for (int i = 0; i < 6; i++) begin
         rd(1'b0, 32'h8, v);
         checks++;
         if (v !== 32'(5 - i)) begin errors++; $display("FAIL os_count t+%0d: got %0d expected %0d", i + 2, v, 5 - i); end
         checks++;
         if (b1.irq !== 1'b0) begin errors++; $display("FAIL os_irq_early t+%0d: got %b expected 0", i + 2, b1.irq); end
         step(1);
      end
      checks++;                          // t+8
      if (b1.irq !== 1'b1) begin errors++; $display("FAIL os_irq_rise: got %b expected 1", b1.irq); end
      step(1);                           // t+9
      rd(1'b0, 32'h0, v);
      checks++;
      if (v !== 32'h8) begin errors++; $display("FAIL os_ctrl_en_clr: got %h expected 8", v); end
      step(3);
      checks++;
      if (b1.irq !== 1'b1) begin errors++; $display("FAIL os_irq_hold: got %b expected 1", b1.irq); end
      wr(1'b0, 32'h0, 4'hF, 32'h8);
      checks++;
      if (b1.irq !== 1'b0) begin errors++; $display("FAIL os_irq_clear: got %b expected 0", b1.irq); end
   endtask

   task automatic test_auto_reload;
      logic [31:0] v;
      logic        exp;
      wr(1'b0, 32'h4, 4'hF, 32'd2);
      wr(1'b0, 32'h0, 4'hF, 32'hB);      // edge t
      for (int k = 1; k <= 16; k++) begin
         step(1);
         exp = (k >= 5) && (k % 5 == 0);
         checks++;
         if (b1.irq !== exp) begin errors++; $display("FAIL ar_irq t+%0d: got %b expected %b", k, b1.irq, exp); end
      end
      rd(1'b0, 32'h0, v);
      checks++;
      if (v !== 32'hB) begin errors++; $display("FAIL ar_ctrl_en: got %h expected b", v); end
      wr(1'b0, 32'h0, 4'hF, 32'h0);
      step(2);
   endtask

   task automatic test_mask_partial;
      logic [31:0] v;
      wr(1'b0, 32'h4, 4'hF, 32'd3);
      wr(1'b0, 32'h4, 4'b0011, 32'h77);
      rd(1'b0, 32'h4, v);
      checks++;
      if (v !== 32'd3) begin errors++; $display("FAIL mp_partial_preset: got %h expected 3", v); end
      wr(1'b0, 32'h8, 4'hF, 32'h55);
      rd(1'b0, 32'h8, v);
      checks++;
      if (v !== 32'd2) begin errors++; $display("FAIL mp_count_ro: got %h expected 2", v); end
      wr(1'b0, 32'hC, 4'hF, 32'hFF);
      rd(1'b0, 32'hC, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL mp_reserved: got %h expected 0", v); end
      wr(1'b0, 32'h0, 4'hF, 32'h1);      // edge t, pend expected at t+6
      for (int k = 1; k <= 10; k++) begin
         step(1);
         checks++;
         if (b1.irq !== 1'b0) begin errors++; $display("FAIL mp_irq_masked t+%0d: got %b expected 0", k, b1.irq); end
         checks++;
         if (u_dut1.r_irq_pend !== (k >= 6)) begin
            errors++; $display("FAIL mp_pend t+%0d: got %b expected %b", k, u_dut1.r_irq_pend, k >= 6);
         end
      end
      wr(1'b0, 32'h0, 4'hF, 32'hFFFF_FFF8);
      rd(1'b0, 32'h0, v);
      checks++;
      if (v !== 32'h8) begin errors++; $display("FAIL mp_ctrl_upper: got %h expected 8", v); end
      checks++;
      if (b1.irq !== 1'b0) begin errors++; $display("FAIL mp_pend_cleared: got %b expected 0", b1.irq); end
   endtask

   task automatic test_pause;
      logic [31:0] v;
      wr(1'b0, 32'h4, 4'hF, 32'd10);
      wr(1'b0, 32'h0, 4'hF, 32'h1);      // edge t
      step(3);
      wr(1'b0, 32'h0, 4'hF, 32'h1);      // edge t+4, count 8
      wr(1'b0, 32'h0, 4'hF, 32'h0);      // edge t+5, count 7
      rd(1'b0, 32'h8, v);
      checks++;
      if (v !== 32'd7) begin errors++; $display("FAIL pause_count: got %0d expected 7", v); end
      step(4);
      rd(1'b0, 32'h8, v);
      checks++;
      if (v !== 32'd7) begin errors++; $display("FAIL pause_hold: got %0d expected 7", v); end
      wr(1'b0, 32'h4, 4'hF, 32'd4);
      wr(1'b0, 32'h0, 4'hF, 32'h1);      // edge u
      step(1);
      rd(1'b0, 32'h8, v);
      checks++;
      if (v !== 32'd7) begin errors++; $display("FAIL pause_preload: got %0d expected 7", v); end
      step(1);
      rd(1'b0, 32'h8, v);
      checks++;
      if (v !== 32'd4) begin errors++; $display("FAIL pause_reload: got %0d expected 4", v); end
      wr(1'b0, 32'h4, 4'hF, 32'd9);      // edge u+3
      rd(1'b0, 32'h8, v);
      checks++;
      if (v !== 32'd3) begin errors++; $display("FAIL preset_in_cnt: got %0d expected 3", v); end
      wr(1'b0, 32'h0, 4'hF, 32'h0);
      step(2);
   endtask

   task automatic test_prescaler;
      logic [31:0] v;
      logic [31:0] exp_c;
      wr(1'b1, 32'h4, 4'hF, 32'd2);
      wr(1'b1, 32'h0, 4'hF, 32'h9);      // edge t
      for (int k = 1; k <= 14; k++) begin
         step(1);
         exp_c = (k < 2) ? 32'd0 : (k < 6) ? 32'd2 : (k < 10) ? 32'd1 : 32'd0;
         rd(1'b1, 32'h8, v);
         checks++;
         if (v !== exp_c) begin errors++; $display("FAIL ps_count t+%0d: got %0d expected %0d", k, v, exp_c); end
         checks++;
         if (b4.irq !== (k == 14)) begin errors++; $display("FAIL ps_irq t+%0d: got %b expected %b", k, b4.irq, k == 14); end
      end
   endtask

   task automatic test_preset_zero;
      wr(1'b0, 32'h4, 4'hF, 32'd0);
      wr(1'b0, 32'h0, 4'hF, 32'h9);      // edge t
      step(2);
      checks++;
      if (b1.irq !== 1'b0) begin errors++; $display("FAIL pz_irq_early: got %b expected 0", b1.irq); end
      step(1);
      checks++;
      if (b1.irq !== 1'b1) begin errors++; $display("FAIL pz_irq_rise: got %b expected 1", b1.irq); end
      step(1);
      wr(1'b0, 32'h0, 4'hF, 32'h0);
      checks++;
      if (b1.irq !== 1'b0) begin errors++; $display("FAIL pz_irq_clear: got %b expected 0", b1.irq); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] v;
      wr(1'b0, 32'h4, 4'hF, 32'd6);
      wr(1'b0, 32'h0, 4'hF, 32'hB);      // edge t
      step(5);                           // t+5
      rd(1'b0, 32'h8, v);
      checks++;
      if (v !== 32'd3) begin errors++; $display("FAIL rm_count_pre: got %0d expected 3", v); end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd(1'b0, 32'(i * 4), v);
         checks++;
         if (v !== 32'd0) begin errors++; $display("FAIL rm_reg%0d: got %h expected 0", i, v); end
      end
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (b1.irq !== 1'b0) begin errors++; $display("FAIL rm_no_irq +%0d: got %b expected 0", k, b1.irq); end
         step(1);
      end
   endtask

   initial begin
      reset = 1'b1;
      b1.sel = 1'b0; b1.addr = 32'd0; b1.byteen = 4'd0; b1.wdata = 32'd0;
      b4.sel = 1'b0; b4.addr = 32'd0; b4.byteen = 4'd0; b4.wdata = 32'd0;
      step(3);
      reset = 1'b0;
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_mask_partial();
      test_pause();
      test_prescaler();
      test_preset_zero();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
